dtw_query_feeder: RTL and testbench

- Upstream sequencer for dtw_core_datapath. Runs one query search per start request.
- Clears the core, then streams SQG_SIZE query samples and ref_len reference samples from two synchronous-read memories, one sample per cycle.
- Waits for the core's done, drains the min/position pipeline, and returns the result over a valid/ready handshake.
- Includes a watchdog and a zero-length guard.

---
 rtl/dtw_query_feeder.sv | 192 +++++++++++++++++++
 tb/tb_dtw_query_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_query_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dtw_query_feeder
// Brief    : Clears the DTW core, streams query/reference samples, drains the
//            min/position pipeline and returns the result via valid/ready.
// Revision : 1.0
// ============================================================================
module dtw_query_feeder #(
  parameter int               WIDTH     = 16,
  parameter int               SQG_SIZE  = 250,
  parameter int               SADDR_W   = 8,
  parameter int               RADDR_W   = 20,
  parameter logic [WIDTH-1:0] PAD       = '1,
  parameter int               DRAIN_CYC = 2,
  parameter int               WD_SLACK  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic               o_busy,
  input  logic [31:0]        i_cfg_ref_len,
  input  logic [RADDR_W-1:0] i_cfg_ref_base,
  output logic               o_sqg_rd_en,
  output logic [SADDR_W-1:0] o_sqg_rd_addr,
  input  logic [WIDTH-1:0]   i_sqg_rd_data,
  output logic               o_ref_rd_en,
  output logic [RADDR_W-1:0] o_ref_rd_addr,
  input  logic [WIDTH-1:0]   i_ref_rd_data,
  output logic               o_core_rst,
  output logic               o_core_running,
  output logic [WIDTH-1:0]   o_core_squiggle,
  output logic [WIDTH-1:0]   o_core_rword,
  output logic [31:0]        o_core_ref_len,
  input  logic [WIDTH-1:0]   i_core_minval,
  input  logic [31:0]        i_core_position,
  input  logic               i_core_done,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [WIDTH-1:0]   o_res_minval,
  output logic [31:0]        o_res_position,
  output logic               o_res_error,
  output logic [31:0]        o_res_cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  // Run index is wide enough for ref_len + SQG_SIZE + WD_SLACK without wrapping.
  localparam int              c_KW    = 34;
  localparam logic [c_KW-1:0] c_EXTRA = c_KW'(SQG_SIZE + WD_SLACK);
  localparam logic [c_KW-1:0] c_SQG   = c_KW'(SQG_SIZE);
  localparam logic [31:0]     c_DLAST = 32'(DRAIN_CYC - 1);

  state_t             r_state;
  logic [31:0]        r_ref_len;
  logic [RADDR_W-1:0] r_base;
  logic [c_KW-1:0]    r_k;
  logic [31:0]        r_dcnt;
  logic [31:0]        r_cycles;
  logic               r_sqg_iss;
  logic               r_ref_iss;

  logic [c_KW-1:0]    w_k_nxt;
  logic [c_KW-1:0]    w_limit;
  logic               w_sqg_nxt;
  logic               w_ref_nxt;
  logic               w_wd_exp;

  assign w_k_nxt   = r_k + c_KW'(1);
  assign w_limit   = {2'b00, r_ref_len} + c_EXTRA;
  assign w_sqg_nxt = (w_k_nxt < c_SQG);
  assign w_ref_nxt = (w_k_nxt < {2'b00, r_ref_len});
  assign w_wd_exp  = (w_k_nxt >= w_limit);

  // The issued flags line up with the synchronous-read latency of both memories.
  assign o_core_squiggle = r_sqg_iss ? i_sqg_rd_data : '0;
  assign o_core_rword    = r_ref_iss ? i_ref_rd_data : PAD;
  assign o_core_rst      = rst || (r_state == S_CLEAR);
  assign o_core_ref_len  = r_ref_len;
  assign o_res_cycles    = r_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ref_len      <= '0;
      r_base         <= '0;
      r_k            <= '0;
      r_dcnt         <= '0;
      r_cycles       <= '0;
      r_sqg_iss      <= 1'b0;
      r_ref_iss      <= 1'b0;
      o_busy         <= 1'b0;
      o_sqg_rd_en    <= 1'b0;
      o_sqg_rd_addr  <= '0;
      o_ref_rd_en    <= 1'b0;
      o_ref_rd_addr  <= '0;
      o_core_running <= 1'b0;
      o_res_valid    <= 1'b0;
      o_res_minval   <= '1;
      o_res_position <= '0;
      o_res_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ref_len <= i_cfg_ref_len;
            r_base    <= i_cfg_ref_base;
            r_cycles  <= '0;
            o_busy    <= 1'b1;
            if (i_cfg_ref_len == 32'd0) begin
              r_state        <= S_RESULT;
              o_res_valid    <= 1'b1;
              o_res_error    <= 1'b1;
              o_res_minval   <= '1;
              o_res_position <= '0;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          r_state        <= S_RUN;
          o_core_running <= 1'b1;
          r_k            <= '0;
          o_sqg_rd_en    <= (SQG_SIZE > 0);
          o_sqg_rd_addr  <= '0;
          o_ref_rd_en    <= 1'b1;
          o_ref_rd_addr  <= r_base;
        end
        S_RUN: begin
          r_cycles <= r_cycles + 32'd1;
          if (i_core_done || w_wd_exp) begin
            o_sqg_rd_en <= 1'b0;
            o_ref_rd_en <= 1'b0;
            r_sqg_iss   <= 1'b0;
            r_ref_iss   <= 1'b0;
            if (i_core_done) begin
              r_state <= S_DRAIN;
              r_dcnt  <= '0;
            end else begin
              r_state        <= S_RESULT;
              o_core_running <= 1'b0;
              o_res_valid    <= 1'b1;
              o_res_error    <= 1'b1;
              o_res_minval   <= i_core_minval;
              o_res_position <= i_core_position;
            end
          end else begin
            r_k           <= w_k_nxt;
            r_sqg_iss     <= o_sqg_rd_en;
            r_ref_iss     <= o_ref_rd_en;
            o_sqg_rd_en   <= w_sqg_nxt;
            o_ref_rd_en   <= w_ref_nxt;
            o_sqg_rd_addr <= w_k_nxt[SADDR_W-1:0];
            o_ref_rd_addr <= r_base + w_k_nxt[RADDR_W-1:0];
          end
        end
        S_DRAIN: begin
          r_cycles <= r_cycles + 32'd1;
          if (r_dcnt >= c_DLAST) begin
            r_state        <= S_RESULT;
            o_core_running <= 1'b0;
            o_res_valid    <= 1'b1;
            o_res_error    <= 1'b0;
            o_res_minval   <= i_core_minval;
            o_res_position <= i_core_position;
          end else begin
            r_dcnt <= r_dcnt + 32'd1;
          end
        end
        S_RESULT: begin
          if (i_res_ready) begin
            r_state     <= S_IDLE;
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtw_query_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtw_query_feeder
// Brief    : Directed self-checking bench with memory models and a core stub.
// Revision : 1.0
// ============================================================================
module tb_dtw_query_feeder;

  localparam int W  = 16;
  localparam int SQ = 4;
  localparam int SA = 8;
  localparam int RA = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic [31:0]   cfg_len = '0;
  logic [RA-1:0] cfg_base = '0;
  logic          sqg_en, ref_en;
  logic [SA-1:0] sqg_addr;
  logic [RA-1:0] ref_addr;
  logic [W-1:0]  sqg_data = '0;
  logic [W-1:0]  ref_data = '0;
  logic          core_rst, core_run;
  logic [W-1:0]  squig, rword;
  logic [31:0]   core_len;
  logic [W-1:0]  c_min = '0;
  logic [31:0]   c_pos = '0;
  logic          c_done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_min;
  logic [31:0]   res_pos;
  logic          res_err;
  logic [31:0]   res_cyc;

  int n_cmp = 0;
  int n_err = 0;

  dtw_query_feeder #(
    .WIDTH(W), .SQG_SIZE(SQ), .SADDR_W(SA), .RADDR_W(RA),
    .PAD(16'hFFFF), .DRAIN_CYC(2), .WD_SLACK(16)
  ) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy),
    .i_cfg_ref_len(cfg_len), .i_cfg_ref_base(cfg_base),
    .o_sqg_rd_en(sqg_en), .o_sqg_rd_addr(sqg_addr), .i_sqg_rd_data(sqg_data),
    .o_ref_rd_en(ref_en), .o_ref_rd_addr(ref_addr), .i_ref_rd_data(ref_data),
    .o_core_rst(core_rst), .o_core_running(core_run),
    .o_core_squiggle(squig), .o_core_rword(rword), .o_core_ref_len(core_len),
    .i_core_minval(c_min), .i_core_position(c_pos), .i_core_done(c_done),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_minval(res_min), .o_res_position(res_pos),
    .o_res_error(res_err), .o_res_cycles(res_cyc)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: the word encodes its own address.
  always @(posedge clk) begin
    if (sqg_en) sqg_data <= {8'h50, sqg_addr};
    if (ref_en) ref_data <= {8'hA0, ref_addr};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start asserted during cycle T0; returns at the falling edge of T1.
  task automatic start_search(input logic [31:0] len, input logic [RA-1:0] base);
    cfg_len  = len;
    cfg_base = base;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    int         run_cnt;
    int         lat;

    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_rst_off", core_rst, 1'b0);
    chk("rst_rword", rword, 16'hFFFF);
    chk("rst_squig", squig, 16'h0);
    chk("rst_res_min", res_min, 16'hFFFF);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_core_len", core_len, 32'd0);

    // Normal search: ref_len 10, base 0x20
    start_search(32'd10, 8'h20);
    chk("t1_clear", core_rst, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_no_run", core_run, 1'b0);
    for (int i = 2; i <= 13; i++) begin
      @(negedge clk);
      chk($sformatf("t1_run_%0d", i), core_run, 1'b1);
      chk($sformatf("t1_core_rst_%0d", i), core_rst, 1'b0);
      chk($sformatf("t1_ref_en_%0d", i), ref_en, (i <= 11));
      if (i <= 11) begin
        a = 8'h20 + 8'(i - 2);
        chk($sformatf("t1_ref_addr_%0d", i), ref_addr, a);
      end
      chk($sformatf("t1_sqg_en_%0d", i), sqg_en, (i <= 5));
      if (i <= 5) chk($sformatf("t1_sqg_addr_%0d", i), sqg_addr, 8'(i - 2));
      if (i >= 3 && i <= 12) begin
        a = 8'h20 + 8'(i - 3);
        chk($sformatf("t1_rword_%0d", i), rword, {8'hA0, a});
      end else begin
        chk($sformatf("t1_rword_pad_%0d", i), rword, 16'hFFFF);
      end
      if (i >= 3 && i <= 6) chk($sformatf("t1_squig_%0d", i), squig, {8'h50, 8'(i - 3)});
      else                  chk($sformatf("t1_squig0_%0d", i), squig, 16'h0);
    end
    chk("t1_core_len", core_len, 32'd10);
    c_done = 1'b1;
    c_min  = 16'h0123;
    c_pos  = 32'd7;

    // Drain after done seen in T13
    @(negedge clk);
    c_done = 1'b0;
    chk("t2_drain_run", core_run, 1'b1);
    chk("t2_drain_valid0", res_valid, 1'b0);
    chk("t2_drain_rword", rword, 16'hFFFF);
    chk("t2_drain_noread", {sqg_en, ref_en}, 2'b00);
    @(negedge clk);
    chk("t2_drain_valid1", res_valid, 1'b0);
    @(negedge clk);
    chk("t2_valid", res_valid, 1'b1);
    chk("t2_min", res_min, 16'h0123);
    chk("t2_pos", res_pos, 32'd7);
    chk("t2_err", res_err, 1'b0);
    chk("t2_cycles", res_cyc, 32'd14);
    chk("t2_run_off", core_run, 1'b0);

    // Back-pressure with an ignored start
    c_min = 16'h0999;
    c_pos = 32'd55;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      chk($sformatf("t3_valid_%0d", i), res_valid, 1'b1);
      chk($sformatf("t3_min_%0d", i), res_min, 16'h0123);
      chk($sformatf("t3_pos_%0d", i), res_pos, 32'd7);
      chk($sformatf("t3_rst_%0d", i), core_rst, 1'b0);
    end
    start = 1'b0;
    handshake();
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_idle_valid", res_valid, 1'b0);
    @(negedge clk);
    chk("t3_no_queue_busy", busy, 1'b0);
    chk("t3_no_queue_rst", core_rst, 1'b0);

    // Zero-length guard
    start_search(32'd0, 8'h10);
    chk("t4_valid", res_valid, 1'b1);
    chk("t4_err", res_err, 1'b1);
    chk("t4_min", res_min, 16'hFFFF);
    chk("t4_pos", res_pos, 32'd0);
    chk("t4_no_clear", core_rst, 1'b0);
    chk("t4_no_run", core_run, 1'b0);
    chk("t4_no_read", {sqg_en, ref_en}, 2'b00);
    chk("t4_cycles", res_cyc, 32'd0);
    handshake();
    chk("t4_idle", busy, 1'b0);

    // Watchdog: 10 + 4 + 16 RUN cycles with no done
    c_min = 16'h0456;
    c_pos = 32'd99;
    start_search(32'd10, 8'h30);
    run_cnt = 0;
    lat     = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
      if (core_run) run_cnt++;
    end
    chk("t5_wd_valid", res_valid, 1'b1);
    chk("t5_wd_lat", lat, 31);
    chk("t5_wd_runs", run_cnt, 30);
    chk("t5_wd_err", res_err, 1'b1);
    chk("t5_wd_min", res_min, 16'h0456);
    chk("t5_wd_pos", res_pos, 32'd99);
    chk("t5_wd_cycles", res_cyc, 32'd30);
    handshake();

    // Address wrap, then reset mid-RUN
    start_search(32'd4, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 8'hFE + 8'(i);
      chk($sformatf("t5_wrap_en_%0d", i), ref_en, 1'b1);
      chk($sformatf("t5_wrap_addr_%0d", i), ref_addr, a);
    end
    @(negedge clk);
    chk("t5_wrap_end", ref_en, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_core_rst", core_rst, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_run", core_run, 1'b0);
    chk("t6_reads", {sqg_en, ref_en}, 2'b00);
    chk("t6_addr", {sqg_addr, ref_addr}, 16'h0);
    chk("t6_rword", rword, 16'hFFFF);
    chk("t6_squig", squig, 16'h0);
    chk("t6_core_len", core_len, 32'd0);
    chk("t6_res_min", res_min, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rel", core_rst, 1'b0);

    // Fresh search after reset
    c_min = 16'h0077;
    c_pos = 32'd3;
    start_search(32'd2, 8'h40);
    chk("t6_clear", core_rst, 1'b1);
    @(negedge clk);
    chk("t6_addr0", ref_addr, 8'h40);
    @(negedge clk);
    chk("t6_rword0", rword, 16'hA040);
    chk("t6_addr1", ref_addr, 8'h41);
    c_done = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c_done = 1'b0;
      lat++;
      if (res_valid) break;
    end
    chk("t6_res_valid", res_valid, 1'b1);
    chk("t6_res_lat", lat, 3);
    chk("t6_res_min", res_min, 16'h0077);
    chk("t6_res_pos", res_pos, 32'd3);
    chk("t6_res_err", res_err, 1'b0);
    chk("t6_res_cycles", res_cyc, 32'd4);
    handshake();
    chk("t6_done_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
